// File: rtl/program_streamer.sv
// program_streamer: holds a small program image in RAM and streams it, one byte
// per valid/ready handshake, into the CPU's byte input. A HALT_OP byte or the
// programmed length ends the stream; the CPU error input aborts it.
module program_streamer #(
   parameter int          DEPTH   = 16,
   parameter int          AW      = 4,
   parameter logic [7:0]  HALT_OP = 8'hFF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   input  logic          start,
   input  logic [AW:0]   prog_len,
   input  logic          ready,
   input  logic          error,
   output logic [7:0]    out,
   output logic          valid,
   output logic          busy,
   output logic          done,
   output logic          aborted
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DONE  = 2'd2,
      ST_ABORT = 2'd3
   } state_t;

   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

   state_t          state_r, state_s;
   logic [AW-1:0]   addr_r, addr_s;
   logic [AW:0]     len_r, len_s;
   logic [7:0]      out_r, out_s;
   logic            valid_r, valid_s;
   logic            busy_r, done_r, aborted_r;
   logic [7:0]      mem_r [DEPTH];

   logic [AW:0]     len_clamp_s;
   logic [AW:0]     addr_inc_s;
   logic [AW-1:0]   addr_next_s;

   // Clamp the requested length to the RAM depth and form the next read address.
   always_comb begin
      len_clamp_s = prog_len;
      if (prog_len > DEPTH_L) begin
         len_clamp_s = DEPTH_L;
      end else begin
         len_clamp_s = prog_len;
      end
      // Wide increment so "addr+1 == len" is exact even when len equals DEPTH.
      addr_inc_s  = {1'b0, addr_r} + {{AW{1'b0}}, 1'b1};
      addr_next_s = addr_inc_s[AW-1:0];
   end

   // Next-state and next-output logic for the streaming FSM.
   always_comb begin
      state_s = state_r;
      addr_s  = addr_r;
      len_s   = len_r;
      out_s   = out_r;
      valid_s = valid_r;
      case (state_r)
         ST_IDLE, ST_DONE, ST_ABORT: begin
            if (start) begin
               if (len_clamp_s == {(AW+1){1'b0}}) begin
                  state_s = ST_DONE;
                  valid_s = 1'b0;
                  out_s   = 8'h00;
               end else begin
                  state_s = ST_RUN;
                  len_s   = len_clamp_s;
                  addr_s  = {AW{1'b0}};
                  out_s   = mem_r[{AW{1'b0}}];
                  valid_s = 1'b1;
               end
            end else begin
               valid_s = 1'b0;
               out_s   = 8'h00;
            end
         end
         ST_RUN: begin
            // error outranks a same-cycle handshake: that byte is not delivered.
            if (error) begin
               state_s = ST_ABORT;
               valid_s = 1'b0;
               out_s   = 8'h00;
            end else if (valid_r && ready) begin
               if ((out_r == HALT_OP) || (addr_inc_s == len_r)) begin
                  state_s = ST_DONE;
                  valid_s = 1'b0;
                  out_s   = 8'h00;
               end else begin
                  addr_s  = addr_next_s;
                  out_s   = mem_r[addr_next_s];
                  valid_s = 1'b1;
               end
            end else begin
               state_s = ST_RUN;
            end
         end
         default: begin
            state_s = ST_IDLE;
            valid_s = 1'b0;
            out_s   = 8'h00;
         end
      endcase
   end

   // State, datapath and registered status decodes.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         addr_r    <= {AW{1'b0}};
         len_r     <= {(AW+1){1'b0}};
         out_r     <= 8'h00;
         valid_r   <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         aborted_r <= 1'b0;
      end else begin
         state_r   <= state_s;
         addr_r    <= addr_s;
         len_r     <= len_s;
         out_r     <= out_s;
         valid_r   <= valid_s;
         busy_r    <= (state_s == ST_RUN);
         done_r    <= (state_s == ST_DONE);
         aborted_r <= (state_s == ST_ABORT);
      end
   end

   // Program RAM load port; closed while streaming and yields to start.
   always_ff @(posedge clk) begin
      if (wr_en && !start && (state_r != ST_RUN)) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   assign out     = out_r;
   assign valid   = valid_r;
   assign busy    = busy_r;
   assign done    = done_r;
   assign aborted = aborted_r;

endmodule

// File: tb/tb_program_streamer.sv
// Scoreboard bench for program_streamer: the driver pushes each stream's expected
// bytes (derived from a model RAM and the length/halt rules), a negedge monitor
// pops and compares every handshaked byte and checks hold-while-stalled.
module tb_program_streamer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       wr_en = 1'b0;
   logic [3:0] wr_addr = 4'd0;
   logic [7:0] wr_data = 8'h00;
   logic       start = 1'b0;
   logic [4:0] prog_len = 5'd0;
   logic       ready = 1'b0;
   logic       error = 1'b0;
   logic [7:0] out;
   logic       valid, busy, done, aborted;

   int checks = 0;
   int errors = 0;

   logic [7:0] mem_m [16];
   logic [7:0] q [$];

   program_streamer #(.DEPTH(16), .AW(4), .HALT_OP(8'hFF)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .prog_len(prog_len), .ready(ready), .error(error),
      .out(out), .valid(valid), .busy(busy), .done(done), .aborted(aborted)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int a, input logic [7:0] d);
      wr_en = 1'b1; wr_addr = a[3:0]; wr_data = d;
      tick();
      wr_en = 1'b0;
      mem_m[a] = d;
   endtask

   // Expected stream: bytes 0..len-1 (len clamped to 16), cut after the first halt byte.
   task automatic begin_stream(input int len);
      int l;
      l = (len > 16) ? 16 : len;
      for (int i = 0; i < l; i++) begin
         q.push_back(mem_m[i]);
         if (mem_m[i] == 8'hFF) break;
      end
      prog_len = len[4:0];
      start = 1'b1;
      tick();
      start = 1'b0;
      wr_en = 1'b0;
      if (l == 0) begin
         chk("zero_len_done", done, 1);
         chk("zero_len_valid", valid, 0);
      end else begin
         chk("start_valid", valid, 1);
         chk("start_busy", busy, 1);
      end
   endtask

   // mode 0: ready always 1; mode 1: ready 1,0,0,...; mode 2: random ready.
   task automatic wait_end(input int mode, input int err_pct);
      int n = 0;
      bit fin = 1'b0;
      while (n < 200 && !fin) begin
         ready = (mode == 0) ? 1'b1 : (mode == 1) ? ((n % 3) == 0) : 1'($urandom_range(0, 1));
         error = (err_pct != 0) && ($urandom_range(0, 99) < err_pct);
         tick();
         n++;
         fin = done || aborted;
      end
      ready = 1'b0;
      error = 1'b0;
      if (!fin) begin
         checks++; errors++;
         $display("FAIL stream_timeout actual=busy expected=done_or_aborted");
      end
      chk("end_valid", valid, 0);
      chk("end_out", out, 0);
      chk("end_busy", busy, 0);
      chk("end_onehot", int'(done) + int'(aborted), 1);
      if (err_pct == 0) chk("end_done", done, 1);
      if (done) chk("queue_empty", q.size(), 0);
      q.delete();
   endtask

   // Monitor: a byte is delivered at the next edge when valid && ready && !error.
   initial begin
      bit hold_pending = 1'b0;
      logic [7:0] hold_val = 8'h00;
      logic [7:0] exp_b;
      forever begin
         @(negedge clk);
         if (!reset && valid) begin
            if (hold_pending) chk("hold_stable", out, hold_val);
            if (ready && !error) begin
               if (q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_byte actual=%0h expected=none", out);
               end else begin
                  exp_b = q.pop_front();
                  chk("stream_byte", out, exp_b);
               end
            end
            hold_pending = !ready && !error;
            hold_val = out;
         end else begin
            hold_pending = 1'b0;
         end
      end
   end

   initial begin
      tick(); tick();
      reset = 1'b0;
      chk("rst_out", out, 0);
      chk("rst_valid", valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_aborted", aborted, 0);

      // Basic stream at full rate, then error in DONE is ignored.
      load(0, 8'h11); load(1, 8'h22); load(2, 8'h33); load(3, 8'h44);
      begin_stream(4);
      wait_end(0, 0);
      error = 1'b1; tick(); error = 1'b0;
      chk("done_err_ignored", done, 1);

      // Stalled stream: ready 1,0,0 pattern.
      begin_stream(4);
      wait_end(1, 0);

      // Abort while 22 is presented and stalled; restart replays from 11.
      begin_stream(4);
      ready = 1'b1; tick();
      ready = 1'b0; error = 1'b1; tick(); error = 1'b0;
      chk("abort_flag", aborted, 1);
      chk("abort_valid", valid, 0);
      chk("abort_out", out, 0);
      chk("abort_remaining", q.size(), 3);
      q.delete();
      begin_stream(4);
      wait_end(0, 0);

      // Write during RUN has no effect; reset mid-RUN discards; start+wr_en drops write.
      begin_stream(4);
      wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'hAA;
      tick();
      wr_en = 1'b0;
      wait_end(0, 0);
      begin_stream(4);
      ready = 1'b1; tick(); ready = 1'b0;
      reset = 1'b1; tick(); reset = 1'b0;
      chk("midrst_valid", valid, 0);
      chk("midrst_out", out, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_aborted", aborted, 0);
      q.delete();
      wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'h5A;
      begin_stream(4);
      wait_end(0, 0);

      // Halt byte ends the stream after delivery.
      load(0, 8'h05); load(1, 8'hFF); load(2, 8'h07);
      begin_stream(3);
      wait_end(0, 0);

      // Zero length.
      begin_stream(0);
      tick();
      chk("zero_len_no_valid", valid, 0);
      wait_end(0, 0);

      // Randomized images, lengths (including clamp), ready and errors.
      for (int it = 0; it < 25; it++) begin
         for (int a = 0; a < 16; a++) begin
            load(a, ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 254)));
         end
         begin_stream(int'($urandom_range(0, 20)));
         wait_end(2, ((it % 3) == 0) ? 5 : 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
